// File: rtl/ctrl_pipeline_pkg.sv
// ctrl_pipeline_pkg: shared types and constants for the control-word pipeline.
//   mdu_state_t    : MDU sequencer states (IDLE / BUSY / DONE)
//   CTRL_W_DEFAULT : default control-bundle width
//   MAX_EX_STAGES  : deepest execute split the pipeline is built for
package ctrl_pipeline_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int CTRL_W_DEFAULT = 10;
  localparam int MAX_EX_STAGES  = 4;
endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one {valid, ctrl} pipeline stage register.
//   clk, reset : clock, synchronous active-high reset
//   bubble     : load an empty stage instead of the input
//   vld_in     : incoming valid
//   ctrl_in    : incoming control bundle
//   vld, ctrl  : registered stage contents
module ctrl_stage_reg #(
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              vld_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl
);
  // An empty stage always carries ctrl = 0 so reg_write/mem_write stay low
  // in bubbles regardless of what sat on the decode bus.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      vld  <= 1'b0;
      ctrl <= '0;
    end else begin
      vld  <= vld_in;
      ctrl <= vld_in ? ctrl_in : '0;
    end
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: decoded-control pipeline E1..En -> M -> W with valid bits,
// hazard stall / execute flush bubble injection and a multicycle MDU
// busy sequencer that holds decode while a dependent MDU op waits.
//   clk, reset          : clock, synchronous active-high reset
//   ctrl_decode         : control bundle from the decoders
//   valid_decode        : decode holds a real instruction
//   stall_decode        : hazard-unit stall
//   flush_execute       : squash the instruction entering execute
//   mdu_use_decode      : decode op starts the MDU
//   mdu_read_decode     : decode op reads HI/LO
//   ctrl_execute(_last) : EX stage 1 / final EX stage control
//   ctrl_memory/_writeback, valid_* : later stage contents
//   stall_out           : decode/fetch hold (combinational)
//   mdu_busy, mdu_done  : MDU in flight / one-cycle result-ready pulse
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEFAULT,
  parameter int EX_STAGES  = 1,
  parameter int MDU_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_decode,
  input  logic              valid_decode,
  input  logic              stall_decode,
  input  logic              flush_execute,
  input  logic              mdu_use_decode,
  input  logic              mdu_read_decode,
  output logic [CTRL_W-1:0] ctrl_execute,
  output logic [CTRL_W-1:0] ctrl_execute_last,
  output logic [CTRL_W-1:0] ctrl_memory,
  output logic [CTRL_W-1:0] ctrl_writeback,
  output logic              valid_execute,
  output logic              valid_memory,
  output logic              valid_writeback,
  output logic              stall_out,
  output logic              mdu_busy,
  output logic              mdu_done
);
  localparam int STAGES = EX_STAGES + 2;  // E1..En, M, W
  localparam int CNT_W  = $clog2(MDU_CYCLES);

  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_pipe;

  logic mdu_stall, accept;

  assign mdu_stall = mdu_busy & (mdu_use_decode | mdu_read_decode) & valid_decode;
  assign stall_out = stall_decode | mdu_stall;
  assign accept    = valid_decode & mdu_use_decode & ~stall_out & ~flush_execute;

  // Only E1 can take a bubble; later stages always advance.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_e1
      ctrl_stage_reg #(.CTRL_W(CTRL_W)) u_reg (
        .clk    (clk),
        .reset  (reset),
        .bubble (stall_out | flush_execute),
        .vld_in (valid_decode),
        .ctrl_in(ctrl_decode),
        .vld    (vld_pipe[g]),
        .ctrl   (ctrl_pipe[g])
      );
    end else begin : g_rest
      ctrl_stage_reg #(.CTRL_W(CTRL_W)) u_reg (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .vld_in (vld_pipe[g-1]),
        .ctrl_in(ctrl_pipe[g-1]),
        .vld    (vld_pipe[g]),
        .ctrl   (ctrl_pipe[g])
      );
    end
  end

  assign ctrl_execute      = ctrl_pipe[0];
  assign valid_execute     = vld_pipe[0];
  assign ctrl_execute_last = ctrl_pipe[EX_STAGES-1];
  assign ctrl_memory       = ctrl_pipe[EX_STAGES];
  assign valid_memory      = vld_pipe[EX_STAGES];
  assign ctrl_writeback    = ctrl_pipe[EX_STAGES+1];
  assign valid_writeback   = vld_pipe[EX_STAGES+1];

  // MDU sequencer
  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Loading MDU_CYCLES-1 gives MDU_CYCLES-1 BUSY cycles then one DONE cycle.
  // DONE accepts a new op directly so back-to-back MDU ops lose no cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(MDU_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mdu_busy = (state == BUSY);
    mdu_done = (state == DONE);
  end
endmodule

// File: tb/tb_ctrl_pipeline.sv
module tb_ctrl_pipeline;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] ctrl_decode;
  logic          valid_decode, stall_decode, flush_execute;
  logic          mdu_use_decode, mdu_read_decode;
  logic [CW-1:0] ctrl_execute, ctrl_execute_last, ctrl_memory, ctrl_writeback;
  logic          valid_execute, valid_memory, valid_writeback;
  logic          stall_out, mdu_busy, mdu_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.CTRL_W(CW), .EX_STAGES(2), .MDU_CYCLES(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl_decode      (ctrl_decode),
    .valid_decode     (valid_decode),
    .stall_decode     (stall_decode),
    .flush_execute    (flush_execute),
    .mdu_use_decode   (mdu_use_decode),
    .mdu_read_decode  (mdu_read_decode),
    .ctrl_execute     (ctrl_execute),
    .ctrl_execute_last(ctrl_execute_last),
    .ctrl_memory      (ctrl_memory),
    .ctrl_writeback   (ctrl_writeback),
    .valid_execute    (valid_execute),
    .valid_memory     (valid_memory),
    .valid_writeback  (valid_writeback),
    .stall_out        (stall_out),
    .mdu_busy         (mdu_busy),
    .mdu_done         (mdu_done)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic          v, st, fl, mu, mr;
    logic          so;
    logic [CW-1:0] e1c;
    logic          e1v;
    logic [CW-1:0] e2c;
    logic [CW-1:0] mc;
    logic          mv;
    logic [CW-1:0] wc;
    logic          wv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [CW-1:0] c, logic v, logic st, logic fl,
                              logic mu, logic mr, logic so,
                              logic [CW-1:0] e1c, logic e1v, logic [CW-1:0] e2c,
                              logic [CW-1:0] mc, logic mv,
                              logic [CW-1:0] wc, logic wv);
    vec_t r;
    r.c = c; r.v = v; r.st = st; r.fl = fl; r.mu = mu; r.mr = mr; r.so = so;
    r.e1c = e1c; r.e1v = e1v; r.e2c = e2c; r.mc = mc; r.mv = mv;
    r.wc = wc; r.wv = wv;
    return r;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge, one settle step before checks.
  task automatic drive(input logic [CW-1:0] c, input logic v, input logic st,
                       input logic fl, input logic mu, input logic mr);
    @(negedge clk);
    ctrl_decode = c; valid_decode = v; stall_decode = st;
    flush_execute = fl; mdu_use_decode = mu; mdu_read_decode = mr;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive('0, 0, 0, 0, 0, 0);
    edge_wait();
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;

    // Stream 1..5, stall bubble, stall+flush bubble, invalid with junk ctrl,
    // flush alone, mflo while MDU idle (no stall).
    tbl.push_back(mk(10'h001,1,0,0,0,0, 0, 10'h001,1, 10'h000, 10'h000,0, 10'h000,0));
    tbl.push_back(mk(10'h002,1,0,0,0,0, 0, 10'h002,1, 10'h001, 10'h000,0, 10'h000,0));
    tbl.push_back(mk(10'h003,1,0,0,0,0, 0, 10'h003,1, 10'h002, 10'h001,1, 10'h000,0));
    tbl.push_back(mk(10'h004,1,0,0,0,0, 0, 10'h004,1, 10'h003, 10'h002,1, 10'h001,1));
    tbl.push_back(mk(10'h005,1,0,0,0,0, 0, 10'h005,1, 10'h004, 10'h003,1, 10'h002,1));
    tbl.push_back(mk(10'h155,1,1,0,0,0, 1, 10'h000,0, 10'h005, 10'h004,1, 10'h003,1));
    tbl.push_back(mk(10'h155,1,0,0,0,0, 0, 10'h155,1, 10'h000, 10'h005,1, 10'h004,1));
    tbl.push_back(mk(10'h0AA,1,1,1,0,0, 1, 10'h000,0, 10'h155, 10'h000,0, 10'h005,1));
    tbl.push_back(mk(10'h3FF,0,0,0,0,0, 0, 10'h000,0, 10'h000, 10'h155,1, 10'h000,0));
    tbl.push_back(mk(10'h000,0,0,0,0,0, 0, 10'h000,0, 10'h000, 10'h000,0, 10'h155,1));
    tbl.push_back(mk(10'h000,0,0,0,0,0, 0, 10'h000,0, 10'h000, 10'h000,0, 10'h000,0));
    tbl.push_back(mk(10'h0C3,1,0,1,0,0, 0, 10'h000,0, 10'h000, 10'h000,0, 10'h000,0));
    tbl.push_back(mk(10'h0C3,1,0,0,0,1, 0, 10'h0C3,1, 10'h000, 10'h000,0, 10'h000,0));

    // Reset wins over a valid decode instruction
    reset = 1'b1;
    drive(10'h3FF, 1, 0, 0, 0, 0);
    edge_wait();
    edge_wait();
    chk("rst_ctrl_e1", ctrl_execute, 0);
    chk("rst_valid_all", {valid_execute, valid_memory, valid_writeback}, 0);
    chk("rst_ctrl_w", ctrl_writeback, 0);
    chk("rst_busy_done", {mdu_busy, mdu_done}, 0);
    drive('0, 0, 0, 0, 0, 0);
    chk("rst_stall_out", stall_out, 0);
    reset = 1'b0;
    edge_wait();

    foreach (tbl[i]) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].mu, tbl[i].mr);
      chk($sformatf("v%0d_stall_out", i), stall_out, tbl[i].so);
      edge_wait();
      chk($sformatf("v%0d_e1", i), {valid_execute, ctrl_execute}, {tbl[i].e1v, tbl[i].e1c});
      chk($sformatf("v%0d_e2", i), ctrl_execute_last, tbl[i].e2c);
      chk($sformatf("v%0d_m", i), {valid_memory, ctrl_memory}, {tbl[i].mv, tbl[i].mc});
      chk($sformatf("v%0d_w", i), {valid_writeback, ctrl_writeback}, {tbl[i].wv, tbl[i].wc});
    end
    repeat (4) idle();

    // mult accepted, then mflo waits in decode until DONE
    drive(10'h010, 1, 0, 0, 1, 0);
    chk("mult_stall_out", stall_out, 0);
    edge_wait();
    chk("mult_e1", {valid_execute, ctrl_execute}, {1'b1, 10'h010});
    busy_cnt = mdu_busy ? 1 : 0;
    done_cnt = mdu_done ? 1 : 0;
    for (int c = 1; c <= 6; c++) begin
      drive(10'h020, 1, 0, 0, 0, 1);
      chk($sformatf("mflo_hold%0d", c), stall_out, 1);
      edge_wait();
      chk($sformatf("mflo_bubble%0d", c), valid_execute, 0);
      if (mdu_busy) busy_cnt++;
      if (mdu_done) done_cnt++;
    end
    chk("mdu_busy_cycles", busy_cnt, 7);
    chk("mdu_done_early", done_cnt, 0);
    drive(10'h020, 1, 0, 0, 0, 1);
    chk("mflo_hold7", stall_out, 1);
    edge_wait();
    chk("done_state", {mdu_busy, mdu_done}, 2'b01);
    chk("mflo_bubble7", valid_execute, 0);
    drive(10'h020, 1, 0, 0, 0, 1);
    chk("mflo_release", stall_out, 0);
    edge_wait();
    chk("mflo_accepted", {valid_execute, ctrl_execute}, {1'b1, 10'h020});
    chk("after_done", {mdu_busy, mdu_done}, 2'b00);
    idle();

    // Back-to-back: new mult accepted while in DONE
    drive(10'h011, 1, 0, 0, 1, 0);
    edge_wait();
    repeat (7) idle();
    chk("b2b_first_done", {mdu_busy, mdu_done}, 2'b01);
    drive(10'h012, 1, 0, 0, 1, 0);
    chk("b2b_no_stall", stall_out, 0);
    edge_wait();
    chk("b2b_busy", {mdu_busy, mdu_done}, 2'b10);
    repeat (7) idle();
    chk("b2b_second_done", {mdu_busy, mdu_done}, 2'b01);
    idle();

    // Squashed mult never starts the MDU
    drive(10'h013, 1, 0, 1, 1, 0);
    edge_wait();
    chk("flush_mult_busy", mdu_busy, 0);
    chk("flush_mult_e1", valid_execute, 0);
    for (int c = 0; c < 9; c++) begin
      idle();
      chk($sformatf("flush_mult_idle%0d", c), {mdu_busy, mdu_done}, 0);
    end

    // Reset on the third BUSY cycle: straight to IDLE, no done pulse
    drive(10'h014, 1, 0, 0, 1, 0);
    edge_wait();
    idle();
    idle();
    chk("pre_reset_busy", mdu_busy, 1);
    reset = 1'b1;
    drive(10'h015, 1, 0, 0, 0, 0);
    edge_wait();
    chk("mid_rst_busy_done", {mdu_busy, mdu_done}, 0);
    chk("mid_rst_valid", {valid_execute, valid_memory, valid_writeback}, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (mdu_done || mdu_busy) done_cnt++;
    end
    chk("post_rst_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
